dcache_writeline_arbiter: RTL and testbench
===========================================

# dcache_writeline_arbiter

Shares the single Avalon burst-write master between the two D-cache line-writeback sources: dirty-line eviction from the miss path (requester 0) and the WBINVD flush walk of the dcache control RAM (requester 1). It arbitrates round-robin, latches the granted 128-bit line and serialises it into a 4-beat, 32-bit Avalon write burst. It returns a per-requester `done` on final-beat acceptance.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- evict_do  in  1  requester 0 write-line request; held high until evict_done
- evict_address  in  32  requester 0 line address; bits [3:0] ignored
- evict_line  in  128  requester 0 line data; word n = bits [32n+31:32n]
- evict_done  out  1  requester 0 completion pulse
- wbinvd_do  in  1  requester 1 write-line request; held high until wbinvd_done
- wbinvd_address  in  32  requester 1 line address; bits [3:0] ignored
- wbinvd_line  in  128  requester 1 line data
- wbinvd_done  out  1  requester 1 completion pulse
- avm_address  out  30  word address [31:2]
- avm_writedata  out  32  burst beat data
- avm_byteenable  out  4  always 4'hF
- avm_burstcount  out  3  always 3'd4
- avm_write  out  1  write strobe
- avm_waitrequest  in  1  slave stall
- busy  out  1  burst in progress

## Operation
- State machine: IDLE, BURST. Reset enters IDLE.
- Registers:
  - beat[1:0]
  - grant (0 = evict, 1 = wbinvd)
  - last_grant, reset 1'b1, so evict wins the first tie
  - addr_q[31:4]
  - line_q[127:0]
- IDLE behaviour:
  - One requester asserting do: that requester wins.
  - Both asserting do: the requester not equal to last_grant wins.
  - On a win, latch address[31:4] and line, set grant and last_grant, clear beat, and go to BURST next cycle.
  - No request: stay in IDLE.
- BURST outputs:
  - avm_write = 1
  - avm_address = {addr_q, 2'b00}, constant for the whole burst
  - avm_writedata = line_q[32*beat +: 32]
  - avm_burstcount = 4
- BURST stepping:
  - Beat accepted when avm_write & ~avm_waitrequest; beat increments on acceptance.
  - Acceptance with beat == 3: assert the granted requester's done combinationally in that same cycle, then return to IDLE next cycle.
- Outside BURST: avm_write = 0 and avm_writedata = 0.
- busy = (state == BURST).
- Latched data: inputs are sampled only at grant. Changes to address, line or do during BURST are ignored, and the burst always completes.
  - If a requester drops do mid-burst, its done still pulses.
- Done pulses: exactly one done pulse per grant, never both in one cycle.

## Timing
- Reset values of all outputs are 0, except the constants avm_byteenable = 4'hF and avm_burstcount = 3'd4. State = IDLE, beat = 0, last_grant = 1.
- Latency with no waitrequest:
  - do high in cycle T (IDLE) → avm_write in T+1..T+4.
  - done in T+4, IDLE in T+5.
- Each waitrequest cycle adds one cycle. Data and address are held stable while waitrequest = 1.
- done is combinational in the final-acceptance cycle. The requester deasserts do in the next cycle (IDLE), so no spurious re-grant occurs.
- Back-to-back: a requester still asserting do in the IDLE cycle after done is treated as a new request.
  - With the other requester also pending, round-robin gives the other requester the grant.
- Minimum spacing between bursts is 1 IDLE cycle.
- Reset mid-burst: immediately return to IDLE, avm_write = 0, no done. Requesters re-arbitrate after reset release.

## Test plan
- Single evict:
  - Stimulus: evict_address = 32'h0001_2345, line = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, no waitrequest.
  - Required: avm_address = 30'h0000_48D0 for 4 cycles; data AAAA…, BBBB…, CCCC…, DDDD…; evict_done in the 4th write cycle only.
- Simultaneous requests from reset:
  - Stimulus: evict_do and wbinvd_do raised in the same cycle.
  - Required: evict burst first, one IDLE cycle, then the wbinvd burst.
  - Required: a second simultaneous pair is served wbinvd first only if last_grant = evict; alternation is verified over 8 requests.
- Waitrequest stall:
  - Stimulus: waitrequest high on beats 0 and 2 for 3 cycles each.
  - Required: writedata held per beat, done after 10 write cycles total, exactly 4 acceptances.
- Input change mid-burst:
  - Stimulus: wbinvd_line and address altered and do dropped after beat 1.
  - Required: the burst completes with the latched values and wbinvd_done pulses once.
- Reset during beat 2:
  - Required: avm_write low and busy low immediately, no done.
  - Required: after release with evict_do high, a fresh 4-beat burst starts at beat 0.

Source files
------------

// File: rtl/dcache_writeline_arbiter.sv
// dcache_writeline_arbiter: round-robin share of the Avalon burst-write master between
// dirty-line eviction (0) and the WBINVD flush walk (1), serialising a 128-bit line into 4 beats.
module dcache_writeline_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         evict_do,
    input  logic [31:0]  evict_address,
    input  logic [127:0] evict_line,
    output logic         evict_done,
    input  logic         wbinvd_do,
    input  logic [31:0]  wbinvd_address,
    input  logic [127:0] wbinvd_line,
    output logic         wbinvd_done,
    output logic [29:0]  avm_address,
    output logic [31:0]  avm_writedata,
    output logic [3:0]   avm_byteenable,
    output logic [2:0]   avm_burstcount,
    output logic         avm_write,
    input  logic         avm_waitrequest,
    output logic         busy
);
    typedef enum logic {IDLE, BURST} state_e;
    state_e state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic grant_q, grant_d, last_q, last_d;
    logic [27:0] addr_q, addr_d;
    logic [127:0] line_q, line_d;
    logic accept, final_beat;
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{evict_address[3:0], wbinvd_address[3:0]};
    assign busy = (state_q == BURST);
    assign accept = busy && !avm_waitrequest;
    assign final_beat = accept && (beat_q == 2'd3);
    assign evict_done = final_beat && !grant_q;
    assign wbinvd_done = final_beat && grant_q;
    assign avm_write = busy;
    assign avm_address = busy ? {addr_q, 2'b00} : 30'd0;
    assign avm_writedata = busy ? line_q[{beat_q, 5'd0} +: 32] : 32'd0;
    assign avm_byteenable = 4'hF;
    assign avm_burstcount = 3'd4;
    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        grant_d = grant_q;
        last_d = last_q;
        addr_d = addr_q;
        line_d = line_q;
        if (state_q == IDLE && (evict_do || wbinvd_do)) begin
            // on a tie the requester that did not win last time goes next
            grant_d = (evict_do && wbinvd_do) ? !last_q : wbinvd_do;
            last_d = grant_d;
            addr_d = grant_d ? wbinvd_address[31:4] : evict_address[31:4];
            line_d = grant_d ? wbinvd_line : evict_line;
            beat_d = 2'd0;
            state_d = BURST;
        end else if (accept) begin
            beat_d = beat_q + 2'd1;
            state_d = final_beat ? IDLE : BURST;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q <= 2'd0;
            grant_q <= 1'b0;
            last_q <= 1'b1;
            addr_q <= 28'd0;
            line_q <= 128'd0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            grant_q <= grant_d;
            last_q <= last_d;
            addr_q <= addr_d;
            line_q <= line_d;
        end
    end
endmodule

// File: tb/tb_dcache_writeline_arbiter.sv
// tb_dcache_writeline_arbiter: directed and random write-line traffic checked every cycle
// against a transaction-level model of the arbiter.
module tb_dcache_writeline_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic evict_do = 1'b0, wbinvd_do = 1'b0, avm_waitrequest = 1'b0;
    logic [31:0] evict_address = '0, wbinvd_address = '0;
    logic [127:0] evict_line = '0, wbinvd_line = '0;
    logic evict_done, wbinvd_done, avm_write, busy;
    logic [29:0] avm_address;
    logic [31:0] avm_writedata;
    logic [3:0] avm_byteenable;
    logic [2:0] avm_burstcount;

    always #5 clk = ~clk;

    dcache_writeline_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .evict_do(evict_do), .evict_address(evict_address), .evict_line(evict_line), .evict_done(evict_done),
        .wbinvd_do(wbinvd_do), .wbinvd_address(wbinvd_address), .wbinvd_line(wbinvd_line), .wbinvd_done(wbinvd_done),
        .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_burstcount(avm_burstcount), .avm_write(avm_write), .avm_waitrequest(avm_waitrequest), .busy(busy)
    );

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: an active transfer = owner, 4 captured words, word address, count of accepted beats
    bit m_act = 0;
    int m_who = 0, m_acc = 0, m_last = 1;
    logic [31:0] m_w [4];
    logic [29:0] m_adr = '0;
    bit seen_ed = 0, seen_wd = 0;
    logic [31:0] acc_data [$];
    logic [29:0] acc_addr [$];
    int done_who [$];
    int wr_cycles = 0;

    always @(negedge clk) begin
        logic exp_ed, exp_wd;
        logic [127:0] l;
        if (!rst_n) begin
            m_act = 0;
            m_acc = 0;
            m_last = 1;
        end
        exp_ed = m_act && !avm_waitrequest && m_acc == 3 && m_who == 0;
        exp_wd = m_act && !avm_waitrequest && m_acc == 3 && m_who == 1;
        chk("avm_write", avm_write, m_act);
        chk("busy", busy, m_act);
        chk("avm_address", avm_address, m_act ? m_adr : 30'd0);
        chk("avm_writedata", avm_writedata, m_act ? m_w[m_acc] : 32'd0);
        chk("evict_done", evict_done, exp_ed);
        chk("wbinvd_done", wbinvd_done, exp_wd);
        chk("avm_byteenable", avm_byteenable, 4'hF);
        chk("avm_burstcount", avm_burstcount, 3'd4);
        seen_ed = evict_done;
        seen_wd = wbinvd_done;
        if (avm_write) wr_cycles++;
        if (avm_write && !avm_waitrequest) begin
            acc_data.push_back(avm_writedata);
            acc_addr.push_back(avm_address);
        end
        if (evict_done) done_who.push_back(0);
        if (wbinvd_done) done_who.push_back(1);
        if (rst_n) begin
            if (m_act) begin
                if (!avm_waitrequest) begin
                    if (m_acc == 3) m_act = 0;
                    else m_acc++;
                end
            end else if (evict_do || wbinvd_do) begin
                m_who = (evict_do && wbinvd_do) ? 1 - m_last : (evict_do ? 0 : 1);
                m_last = m_who;
                l = m_who ? wbinvd_line : evict_line;
                for (int i = 0; i < 4; i++) m_w[i] = l[32*i +: 32];
                m_adr = (m_who ? wbinvd_address[31:2] : evict_address[31:2]) & ~30'h3;
                m_act = 1;
                m_acc = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_addr.delete();
        done_who.delete();
        wr_cycles = 0;
    endtask

    task automatic wait_done(input int who, input int budget, output int n);
        n = 0;
        while (!(who == 0 ? seen_ed : seen_wd) && n < budget) begin
            cyc();
            n++;
        end
        if (n >= budget) chk("done_timeout", 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int n;
        logic [127:0] l;
        bit [9:0] pat;
        do_reset();

        // single evict, no stall
        clear_log();
        evict_address = 32'h0001_2345;
        evict_line = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        evict_do = 1'b1;
        wait_done(0, 20, n);
        evict_do = 1'b0;
        chk("single_latency", n, 5);
        chk("single_beats", acc_data.size(), 4);
        chk("single_wrcycles", wr_cycles, 4);
        if (acc_data.size() == 4) begin
            chk("single_d0", acc_data[0], 32'hAAAA_AAAA);
            chk("single_d1", acc_data[1], 32'hBBBB_BBBB);
            chk("single_d2", acc_data[2], 32'hCCCC_CCCC);
            chk("single_d3", acc_data[3], 32'hDDDD_DDDD);
            for (int i = 0; i < 4; i++) chk("single_addr", acc_addr[i], 30'h0000_48D0);
        end
        chk("single_dones", done_who.size(), 1);

        // both pending from reset: strict alternation starting with evict
        do_reset();
        clear_log();
        wbinvd_address = 32'h0000_8000;
        wbinvd_line = {4{32'h5A5A_0001}};
        evict_do = 1'b1;
        wbinvd_do = 1'b1;
        n = 0;
        while (done_who.size() < 8 && n < 100) begin
            cyc();
            n++;
        end
        evict_do = 1'b0;
        wbinvd_do = 1'b0;
        chk("rr_cycles", n, 40);
        chk("rr_wrcycles", wr_cycles, 32);
        chk("rr_count", done_who.size(), 8);
        for (int i = 0; i < 8 && i < done_who.size(); i++) chk("rr_order", done_who[i], i % 2);

        // waitrequest stalls beat 0 and beat 2 for 3 cycles each
        cyc();
        clear_log();
        wbinvd_address = 32'h00F0_0010;
        wbinvd_line = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        wbinvd_do = 1'b1;
        pat = 10'b0011100111;
        for (int i = 0; i < 10; i++) begin
            cyc();
            avm_waitrequest = pat[i];
        end
        cyc();
        avm_waitrequest = 1'b0;
        chk("stall_done", seen_wd, 1'b1);
        wbinvd_do = 1'b0;
        chk("stall_wrcycles", wr_cycles, 10);
        chk("stall_beats", acc_data.size(), 4);
        if (acc_data.size() == 4) chk("stall_d2", acc_data[2], 32'h3333_3333);

        // inputs change and do drops after beat 1
        cyc();
        clear_log();
        wbinvd_address = 32'h1234_5670;
        l = {32'h0D0D_0D0D, 32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A};
        wbinvd_line = l;
        wbinvd_do = 1'b1;
        repeat (3) cyc();
        wbinvd_do = 1'b0;
        wbinvd_line = ~l;
        wbinvd_address = 32'hFFFF_FFF0;
        wait_done(1, 20, n);
        repeat (3) cyc();
        chk("chg_dones", done_who.size(), 1);
        chk("chg_beats", acc_data.size(), 4);
        if (acc_data.size() == 4) begin
            chk("chg_d3", acc_data[3], 32'h0D0D_0D0D);
            chk("chg_addr", acc_addr[3], 30'h048D_159C);
        end

        // reset during beat 2, then a fresh burst
        clear_log();
        evict_address = 32'h0000_0100;
        evict_line = {32'h8, 32'h7, 32'h6, 32'h5};
        evict_do = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        chk("rst_write", avm_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) cyc();
        chk("rst_nodone", done_who.size(), 0);
        rst_n = 1'b1;
        clear_log();
        wait_done(0, 20, n);
        evict_do = 1'b0;
        chk("rst_latency", n, 5);
        chk("rst_beats", acc_data.size(), 4);
        if (acc_data.size() == 4) chk("rst_d0", acc_data[0], 32'h5);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            cyc();
            avm_waitrequest = ($urandom_range(0, 3) == 0);
            if (evict_do && seen_ed) begin
                evict_do = $urandom_range(0, 1);
                evict_line = {$urandom, $urandom, $urandom, $urandom};
                evict_address = $urandom;
            end else if (!evict_do && $urandom_range(0, 3) == 0) begin
                evict_do = 1'b1;
                evict_line = {$urandom, $urandom, $urandom, $urandom};
                evict_address = $urandom;
            end else if (busy && $urandom_range(0, 7) == 0) begin
                evict_line = {$urandom, $urandom, $urandom, $urandom};
            end
            if (wbinvd_do && seen_wd) begin
                wbinvd_do = $urandom_range(0, 1);
                wbinvd_line = {$urandom, $urandom, $urandom, $urandom};
                wbinvd_address = $urandom;
            end else if (!wbinvd_do && $urandom_range(0, 3) == 0) begin
                wbinvd_do = 1'b1;
                wbinvd_line = {$urandom, $urandom, $urandom, $urandom};
                wbinvd_address = $urandom;
            end else if (busy && $urandom_range(0, 7) == 0) begin
                wbinvd_address = $urandom;
            end
        end
        evict_do = 1'b0;
        wbinvd_do = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (12) cyc();
        chk("final_idle", busy, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
